// File: rtl/pool_pkg.sv
// pool_pkg
// Shared definitions for the pooling window block:
//   pool_mode_e  - pooling mode encoding (POOL_MAX / POOL_AVG)
//   SAT_W        - working width of the saturate helper
//   sat_signed() - clamps a signed value to the range of a narrower signed width
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    localparam int SAT_W = 64;

    // Clamp value to [-2^(width-1), 2^(width-1)-1]. The caller truncates the
    // returned value to 'width' bits; the result is always representable.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] value,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// pool_lane
// One channel of the pooling window: a signed accumulator plus result logic.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   beat_i       - a beat is accepted this cycle
//   first_i      - this beat starts a window (accumulator loads the sample)
//   mode_i       - effective pooling mode for this beat (pool_mode_e encoding)
//   shift_i      - effective average-mode right shift
//   sample_i     - signed input sample
//   result_o     - pooled result including this beat (combinational)
module pool_lane
    import pool_pkg::*;
#(
    parameter int NUM_WIDTH = 16,
    parameter int CNT_WIDTH = 8,
    parameter int SHIFT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 beat_i,
    input  logic                 first_i,
    input  logic                 mode_i,
    input  logic [SHIFT_W-1:0]   shift_i,
    input  logic [NUM_WIDTH-1:0] sample_i,
    output logic [NUM_WIDTH-1:0] result_o
);

    localparam int ACC_W = NUM_WIDTH + CNT_WIDTH;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] shifted;

    assign sample_ext = {{CNT_WIDTH{sample_i[NUM_WIDTH-1]}}, sample_i};

    always_comb begin
        acc_d = acc_q;
        if (first_i) begin
            acc_d = sample_ext;
        end else if (mode_i == POOL_MAX) begin
            acc_d = (sample_ext > acc_q) ? sample_ext : acc_q;
        end else begin
            acc_d = acc_q + sample_ext;
        end
    end

    // Arithmetic shift floors toward minus infinity.
    assign shifted = acc_d >>> shift_i;

    // Max only ever holds sign-extended samples, so its low bits are exact.
    assign result_o = (mode_i == POOL_MAX)
        ? acc_d[NUM_WIDTH-1:0]
        : NUM_WIDTH'(sat_signed({{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted}, NUM_WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (beat_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pool_window.sv
// pool_window
// Pools CHANNELS lanes of signed samples over a window of cfg_size beats,
// either as a running max or as a shifted, saturated sum.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   restart               - drop any partial window (synchronous)
//   cfg_mode              - 0 = max, 1 = average (latched at window start)
//   cfg_size              - beats per window, 0 treated as 1 (latched)
//   cfg_shift             - average right shift (latched)
//   up_data/valid/ready   - input stream, lane 0 in the LSBs
//   dn_data/valid/ready   - pooled output stream, lane 0 in the LSBs
module pool_window
    import pool_pkg::*;
#(
    parameter int NUM_WIDTH = 16,
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            restart,
    input  logic                            cfg_mode,
    input  logic [CNT_WIDTH-1:0]            cfg_size,
    input  logic [$clog2(CNT_WIDTH+1)-1:0]  cfg_shift,
    input  logic [CHANNELS*NUM_WIDTH-1:0]   up_data,
    input  logic                            up_valid,
    output logic                            up_ready,
    output logic [CHANNELS*NUM_WIDTH-1:0]   dn_data,
    output logic                            dn_valid,
    input  logic                            dn_ready
);

    localparam int SHIFT_W = $clog2(CNT_WIDTH + 1);

    logic [CNT_WIDTH-1:0]          cnt_q;
    logic [CNT_WIDTH-1:0]          cnt_cur;
    logic                          mode_q;
    logic [CNT_WIDTH-1:0]          size_q;
    logic [SHIFT_W-1:0]            shift_q;
    logic                          dn_valid_q;
    logic [CHANNELS*NUM_WIDTH-1:0] dn_data_q;

    logic                          beat;
    logic                          first;
    logic                          mode_eff;
    logic [CNT_WIDTH-1:0]          size_eff;
    logic [SHIFT_W-1:0]            shift_eff;
    logic                          wrap;
    logic [CHANNELS*NUM_WIDTH-1:0] lane_result;

    assign up_ready = !dn_valid_q | dn_ready;
    assign beat     = up_valid & up_ready;

    // A zero count always means "next beat opens a window"; restart forces it
    // for a coinciding beat so that beat picks up fresh configuration.
    assign first     = restart | (cnt_q == '0);
    assign mode_eff  = first ? cfg_mode : mode_q;
    assign size_eff  = first ? ((cfg_size == '0) ? CNT_WIDTH'(1) : cfg_size) : size_q;
    assign shift_eff = first ? cfg_shift : shift_q;
    assign cnt_cur   = first ? '0 : cnt_q;
    assign wrap      = (cnt_cur == size_eff - CNT_WIDTH'(1));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        pool_lane #(
            .NUM_WIDTH (NUM_WIDTH),
            .CNT_WIDTH (CNT_WIDTH),
            .SHIFT_W   (SHIFT_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .beat_i   (beat),
            .first_i  (first),
            .mode_i   (mode_eff),
            .shift_i  (shift_eff),
            .sample_i (up_data[g*NUM_WIDTH +: NUM_WIDTH]),
            .result_o (lane_result[g*NUM_WIDTH +: NUM_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            mode_q  <= POOL_MAX;
            size_q  <= '0;
            shift_q <= '0;
        end else if (beat) begin
            if (first) begin
                mode_q  <= mode_eff;
                size_q  <= size_eff;
                shift_q <= shift_eff;
            end
            cnt_q <= wrap ? '0 : cnt_cur + CNT_WIDTH'(1);
        end else if (restart) begin
            cnt_q <= '0;
        end
    end

    // A beat is only accepted when the output is empty or draining, so a
    // completing window can always overwrite the register with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid_q <= 1'b0;
            dn_data_q  <= '0;
        end else if (beat && wrap) begin
            dn_valid_q <= 1'b1;
            dn_data_q  <= lane_result;
        end else if (dn_ready) begin
            dn_valid_q <= 1'b0;
        end
    end

    assign dn_valid = dn_valid_q;
    assign dn_data  = dn_data_q;

endmodule

// File: tb/tb_pool_window.sv
module tb_pool_window;

    localparam int NW = 16;
    localparam int CH = 4;
    localparam int CW = 8;
    localparam int SW = $clog2(CW + 1);

    logic              clk;
    logic              rst_n;
    logic              restart;
    logic              cfg_mode;
    logic [CW-1:0]     cfg_size;
    logic [SW-1:0]     cfg_shift;
    logic [CH*NW-1:0]  up_data;
    logic              up_valid;
    logic              up_ready;
    logic [CH*NW-1:0]  dn_data;
    logic              dn_valid;
    logic              dn_ready;

    pool_window #(.NUM_WIDTH(NW), .CHANNELS(CH), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .cfg_mode  (cfg_mode),
        .cfg_size  (cfg_size),
        .cfg_shift (cfg_shift),
        .up_data   (up_data),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .dn_data   (dn_data),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_pushed = 0;
    int n_out    = 0;
    bit rand_ready = 1'b0;
    logic [CH*NW-1:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model
    int     m_cnt = 0;
    bit     m_mode = 0;
    int     m_size = 1;
    int     m_shift = 0;
    longint m_acc[CH];

    function automatic int fx(input int whole);
        return whole * 256;
    endfunction

    function automatic logic [CH*NW-1:0] pk(input int a, input int b, input int c, input int d);
        logic [NW-1:0] la, lb, lc, ld;
        la = a[NW-1:0]; lb = b[NW-1:0]; lc = c[NW-1:0]; ld = d[NW-1:0];
        return {ld, lc, lb, la};
    endfunction

    task automatic model_accept(input logic [CH*NW-1:0] data, input bit mode, input int size,
                                input int shift, input bit rs);
        bit first;
        logic [CH*NW-1:0] res;
        first = rs || (m_cnt == 0);
        if (first) begin
            m_mode  = mode;
            m_size  = (size == 0) ? 1 : size;
            m_shift = shift;
            m_cnt   = 0;
        end
        for (int l = 0; l < CH; l++) begin
            logic signed [NW-1:0] s16;
            longint s;
            s16 = data[l*NW +: NW];
            s = s16;
            if (first) m_acc[l] = s;
            else if (!m_mode) m_acc[l] = (s > m_acc[l]) ? s : m_acc[l];
            else m_acc[l] = m_acc[l] + s;
        end
        m_cnt++;
        if (m_cnt == m_size) begin
            m_cnt = 0;
            for (int l = 0; l < CH; l++) begin
                longint v;
                if (!m_mode) v = m_acc[l];
                else begin
                    v = m_acc[l] >>> m_shift;
                    if (v > 32767) v = 32767;
                    if (v < -32768) v = -32768;
                end
                res[l*NW +: NW] = v[NW-1:0];
            end
            sb_q.push_back(res);
            n_pushed++;
        end
    endtask

    // Called and returns at posedge+1.
    task automatic send_beat(input logic [CH*NW-1:0] data, input bit mode, input int size,
                             input int shift, input bit rs);
        bit accepted;
        int guard;
        accepted = 1'b0;
        guard = 0;
        up_data   = data;
        cfg_mode  = mode;
        cfg_size  = CW'(size);
        cfg_shift = SW'(shift);
        restart   = rs;
        up_valid  = 1'b1;
        forever begin
            if (rand_ready) dn_ready = 1'($urandom_range(0, 1));
            #1;
            accepted = up_ready;
            @(posedge clk);
            #1;
            if (accepted) break;
            guard++;
            if (guard > 200) begin
                check("accept_timeout", 64'(accepted), 64'(1));
                break;
            end
        end
        if (accepted) model_accept(data, mode, size, shift, rs);
        up_valid = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && dn_valid && dn_ready) begin
            n_out++;
            if (sb_q.size() > 0) begin
                check("sb_data", 64'(dn_data), 64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0; restart = 1'b0; cfg_mode = 1'b0; cfg_size = '0; cfg_shift = '0;
        up_data = '0; up_valid = 1'b0; dn_ready = 1'b1;
        #12;
        check("rst_dn_valid", 64'(dn_valid), 64'(0));
        check("rst_dn_data",  64'(dn_data),  64'(0));
        check("rst_up_ready", 64'(up_ready), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Max, size 4; later beats carry conflicting config that must be ignored
        send_beat(pk(fx(-13), 100, -5, 7), 0, 4, 0, 0);
        send_beat(pk(fx(-9), -300, 9, 7), 1, 2, 3, 0);
        send_beat(pk(fx(-11), 50, -20, -8), 1, 2, 3, 0);
        send_beat(pk(fx(5), 20, 0, -9), 1, 1, 1, 0);
        check("max_latency", 64'(dn_valid), 64'(1));
        check("max_lane0", 64'(dn_data[15:0]), 64'(16'h0500));
        idle(2);

        // Average, size 4, shift 2
        send_beat(pk(fx(8), fx(-1), 1000, -7), 1, 4, 2, 0);
        send_beat(pk(fx(4), fx(-1), 3, 2), 0, 7, 0, 0);
        send_beat(pk(fx(-4), fx(-1), -77, 5), 0, 7, 0, 0);
        send_beat(pk(fx(0), fx(-1), 12, 1), 0, 7, 0, 0);
        check("avg_lane0", 64'(dn_data[15:0]), 64'(16'h0200));
        check("avg_lane1", 64'(dn_data[31:16]), 64'(16'hFF00));
        idle(1);

        // Average saturation, size 2, shift 0
        send_beat(pk(fx(100), 1, 2, 3), 1, 2, 0, 0);
        send_beat(pk(fx(100), 1, 2, 3), 1, 2, 0, 0);
        check("sat_pos", 64'(dn_data[15:0]), 64'(16'h7FFF));
        send_beat(pk(fx(-100), -1, -2, -3), 1, 2, 0, 0);
        send_beat(pk(fx(-100), -1, -2, -3), 1, 2, 0, 0);
        check("sat_neg", 64'(dn_data[15:0]), 64'(16'h8000));
        idle(2);

        // Restart discards the partial window and restarts on the same beat
        send_beat(pk(fx(-13), 0, 0, 0), 1, 4, 0, 0);
        send_beat(pk(fx(-9), 0, 0, 0), 1, 4, 0, 0);
        send_beat(pk(2099, 5, 6, 7), 0, 4, 0, 1);
        send_beat(pk(128, 8, 9, 10), 1, 2, 1, 0);
        send_beat(pk(-256, 1, 1, 1), 1, 2, 1, 0);
        send_beat(pk(fx(100), 2, 2, 2), 1, 2, 1, 0);
        check("restart_lane0", 64'(dn_data[15:0]), 64'(16'h6400));
        idle(2);

        // Backpressure: output held, input stalled, data stable
        dn_ready = 1'b0;
        send_beat(pk(11, 22, 33, 44), 0, 2, 0, 0);
        send_beat(pk(-11, 99, -33, 55), 0, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("bp_up_ready", 64'(up_ready), 64'(0));
            check("bp_dn_valid", 64'(dn_valid), 64'(1));
            check("bp_dn_stable", 64'(dn_data), 64'(sb_q[0]));
            idle(1);
        end
        dn_ready = 1'b1;
        send_beat(pk(1, 2, 3, 4), 1, 2, 1, 0);
        send_beat(pk(5, 6, 7, 8), 1, 2, 1, 0);
        idle(2);

        // cfg_size = 0 acts as 1: back-to-back windows with no bubble
        for (int i = 0; i < 5; i++) begin
            send_beat(pk(i * 3 - 4, i, -i, 100 + i), 0, 0, 0, 0);
            check("b2b_valid", 64'(dn_valid), 64'(1));
        end
        idle(2);

        // Random windows with random output backpressure
        rand_ready = 1'b1;
        for (int w = 0; w < 6; w++) begin
            bit md;
            int sz, sh;
            md = 1'($urandom_range(0, 1));
            sz = $urandom_range(1, 5);
            sh = $urandom_range(0, 7);
            for (int b = 0; b < sz; b++) begin
                send_beat(CH*NW'({$urandom, $urandom}), md, sz, sh, 0);
            end
        end
        rand_ready = 1'b0;
        dn_ready = 1'b1;
        idle(3);

        // Reset in the middle of a window
        send_beat(pk(fx(50), 1, 1, 1), 0, 4, 0, 0);
        send_beat(pk(fx(60), 1, 1, 1), 0, 4, 0, 0);
        rst_n = 1'b0;
        n_pushed -= sb_q.size();
        sb_q.delete();
        m_cnt = 0;
        #1;
        check("mid_rst_dn_valid", 64'(dn_valid), 64'(0));
        check("mid_rst_dn_data",  64'(dn_data),  64'(0));
        check("mid_rst_up_ready", 64'(up_ready), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        send_beat(pk(fx(-2), 1, 2, 3), 0, 4, 0, 0);
        send_beat(pk(fx(-7), 4, 5, 6), 0, 4, 0, 0);
        send_beat(pk(fx(-1), 7, 8, 9), 0, 4, 0, 0);
        send_beat(pk(fx(-3), 0, 0, 0), 0, 4, 0, 0);
        check("post_rst_lane0", 64'(dn_data[15:0]), 64'(16'hFF00));
        idle(3);

        check("out_count", 64'(n_out), 64'(n_pushed));
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
